// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and types for the register-file write arbiter
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 31;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } rf_wr_req_t;

    typedef enum logic {
        REQ_MEM = 1'b0,
        REQ_ALU = 1'b1
    } rf_req_e;

endpackage

// File: rtl/rf_wb_slot.sv
// rtl/rf_wb_slot.sv - one-entry writeback holding slot with zero-register drop
module rf_wb_slot #(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int ZERO_REG   = rf_pkg::ZERO_REG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  grant,
    output logic                  occupied,
    output logic [ADDR_WIDTH-1:0] slot_addr,
    output logic [DATA_WIDTH-1:0] slot_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic                  occ_q, occ_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  accept;

    // A slot being drained this cycle can be refilled on the same edge.
    assign in_ready = !occ_q || grant;
    assign accept   = in_valid && in_ready;

    always_comb begin
        occ_d  = occ_q;
        addr_d = addr_q;
        data_d = data_q;
        if (grant) begin
            occ_d = 1'b0;
        end
        if (accept && (in_addr != ZERO_ADDR)) begin
            occ_d  = 1'b1;
            addr_d = in_addr;
            data_d = in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            occ_q  <= occ_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign occupied  = occ_q;
    assign slot_addr = addr_q;
    assign slot_data = data_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - ALU/mem writeback arbiter for the register-file write port
// Define RF_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority mem over ALU.
import rf_pkg::*;

module rf_write_arbiter #(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int ZERO_REG   = rf_pkg::ZERO_REG
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       aluValid,
    output logic                       aluReady,
    input  logic [ADDR_WIDTH-1:0]      aluAddress,
    input  logic [DATA_WIDTH-1:0]      aluData,
    input  logic                       memValid,
    output logic                       memReady,
    input  logic [ADDR_WIDTH-1:0]      memAddress,
    input  logic [DATA_WIDTH-1:0]      memData,
    output logic                       writeRegister,
    output logic [ADDR_WIDTH-1:0]      writeAddress,
    output logic [DATA_WIDTH-1:0]      writeData,
    output logic [(1<<ADDR_WIDTH)-1:0] pendingMask
);

    logic                  mem_occ, alu_occ;
    logic [ADDR_WIDTH-1:0] mem_addr, alu_addr;
    logic [DATA_WIDTH-1:0] mem_data, alu_data;
    logic                  grant_mem, grant_alu, any_occ;
    rf_req_e               grant_sel;

    logic                  write_register_q, write_register_d;
    logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    rf_wb_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_mem_slot (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (memValid),
        .in_ready  (memReady),
        .in_addr   (memAddress),
        .in_data   (memData),
        .grant     (grant_mem),
        .occupied  (mem_occ),
        .slot_addr (mem_addr),
        .slot_data (mem_data)
    );

    rf_wb_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_alu_slot (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (aluValid),
        .in_ready  (aluReady),
        .in_addr   (aluAddress),
        .in_data   (aluData),
        .grant     (grant_alu),
        .occupied  (alu_occ),
        .slot_addr (alu_addr),
        .slot_data (alu_data)
    );

`ifdef RF_ARB_ROUND_ROBIN_EN
    rf_req_e rr_q, rr_d;

    // The pointer only breaks ties; a lone occupied slot always wins.
    always_comb begin
        if (mem_occ && alu_occ) begin
            grant_sel = rr_q;
        end else if (alu_occ) begin
            grant_sel = REQ_ALU;
        end else begin
            grant_sel = REQ_MEM;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (any_occ) begin
            rr_d = (grant_sel == REQ_MEM) ? REQ_ALU : REQ_MEM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= REQ_MEM;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        grant_sel = (alu_occ && !mem_occ) ? REQ_ALU : REQ_MEM;
    end
`endif

    assign any_occ   = mem_occ || alu_occ;
    assign grant_mem = any_occ && (grant_sel == REQ_MEM);
    assign grant_alu = any_occ && (grant_sel == REQ_ALU);

    always_comb begin
        write_register_d = grant_mem || grant_alu;
        write_address_d  = write_address_q;
        write_data_d     = write_data_q;
        if (grant_mem) begin
            write_address_d = mem_addr;
            write_data_d    = mem_data;
        end else if (grant_alu) begin
            write_address_d = alu_addr;
            write_data_d    = alu_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_register_q <= 1'b0;
            write_address_q  <= '0;
            write_data_q     <= '0;
        end else begin
            write_register_q <= write_register_d;
            write_address_q  <= write_address_d;
            write_data_q     <= write_data_d;
        end
    end

    assign writeRegister = write_register_q;
    assign writeAddress  = write_address_q;
    assign writeData     = write_data_q;

    // Zero-register writes never enter a slot, so that bit can never appear here.
    always_comb begin
        pendingMask = '0;
        if (mem_occ) begin
            pendingMask[mem_addr] = 1'b1;
        end
        if (alu_occ) begin
            pendingMask[alu_addr] = 1'b1;
        end
        if (write_register_q) begin
            pendingMask[write_address_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed scoreboard bench for rf_write_arbiter
import rf_pkg::*;

module tb_rf_write_arbiter;

    logic                  clock;
    logic                  reset;
    logic                  aluValid, memValid;
    logic                  aluReady, memReady;
    logic [ADDR_WIDTH-1:0] aluAddress, memAddress;
    logic [DATA_WIDTH-1:0] aluData, memData;
    logic                  writeRegister;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0] writeData;
    logic [31:0]           pendingMask;

    rf_write_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .aluValid      (aluValid),
        .aluReady      (aluReady),
        .aluAddress    (aluAddress),
        .aluData       (aluData),
        .memValid      (memValid),
        .memReady      (memReady),
        .memAddress    (memAddress),
        .memData       (memData),
        .writeRegister (writeRegister),
        .writeAddress  (writeAddress),
        .writeData     (writeData),
        .pendingMask   (pendingMask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;
    rf_wr_req_t sb_q[$];
    logic [DATA_WIDTH-1:0] rf_model [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic rf_wr_req_t mk(input int a, input logic [DATA_WIDTH-1:0] d);
        rf_wr_req_t r;
        r.addr = ADDR_WIDTH'(a);
        r.data = d;
        return r;
    endfunction

    // Advance one edge, then score any write the port is presenting.
    task automatic tick();
        rf_wr_req_t e;
        @(posedge clock);
        #1;
        if (writeRegister) begin
            chk("write_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("write_addr", 64'(writeAddress), 64'(e.addr));
                chk("write_data", 64'(writeData), 64'(e.data));
            end
            rf_model[writeAddress] = writeData;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    int mem_rdy, alu_rdy;

    initial begin
        reset = 1'b1;
        aluValid = 1'b0; memValid = 1'b0;
        aluAddress = '0; memAddress = '0;
        aluData = '0; memData = '0;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;

        #12;
        chk("rst_wr", 64'(writeRegister), 64'd0);
        chk("rst_addr", 64'(writeAddress), 64'd0);
        chk("rst_data", 64'(writeData), 64'd0);
        chk("rst_mask", 64'(pendingMask), 64'd0);
        chk("rst_alu_rdy", 64'(aluReady), 64'd1);
        chk("rst_mem_rdy", 64'(memReady), 64'd1);
        reset = 1'b0;
        tick();

        // Single ALU write: visible after the second edge, one cycle wide.
        aluValid = 1'b1; aluAddress = 5'd3; aluData = 32'hDEADBEEF;
        chk("t1_alu_rdy", 64'(aluReady), 64'd1);
        sb_q.push_back(mk(3, 32'hDEADBEEF));
        tick();
        aluValid = 1'b0;
        chk("t1_wr_k", 64'(writeRegister), 64'd0);
        chk("t1_mask_slot", 64'(pendingMask), 64'h8);
        tick();
        chk("t1_wr_k1", 64'(writeRegister), 64'd1);
        chk("t1_mask_port", 64'(pendingMask), 64'h8);
        tick();
        chk("t1_wr_k2", 64'(writeRegister), 64'd0);
        chk("t1_mask_clr", 64'(pendingMask), 64'd0);
        chk("t1_rf3", 64'(rf_model[3]), 64'hDEADBEEF);

        // Same-address conflict: mem issues first, ALU value lands last.
        do_reset();
        aluValid = 1'b1; aluAddress = 5'd7; aluData = 32'h11;
        memValid = 1'b1; memAddress = 5'd7; memData = 32'h22;
        chk("t2_alu_rdy", 64'(aluReady), 64'd1);
        chk("t2_mem_rdy", 64'(memReady), 64'd1);
        sb_q.push_back(mk(7, 32'h22));
        sb_q.push_back(mk(7, 32'h11));
        tick();
        aluValid = 1'b0; memValid = 1'b0;
        tick();
        chk("t2_wr0", 64'(writeRegister), 64'd1);
        tick();
        chk("t2_wr1", 64'(writeRegister), 64'd1);
        tick();
        chk("t2_wr_idle", 64'(writeRegister), 64'd0);
        chk("t2_rf7", 64'(rf_model[7]), 64'h11);
        chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

        // Both requesters continuously busy.
        do_reset();
`ifdef RF_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(mk(5, 32'h5555));
            sb_q.push_back(mk(4, 32'hAAAA));
        end
`else
        for (int i = 0; i < 9; i++) sb_q.push_back(mk(5, 32'h5555));
        sb_q.push_back(mk(4, 32'hAAAA));
`endif
        aluValid = 1'b1; aluAddress = 5'd4; aluData = 32'hAAAA;
        memValid = 1'b1; memAddress = 5'd5; memData = 32'h5555;
        mem_rdy = 0; alu_rdy = 0;
        for (int i = 0; i < 9; i++) begin
            if (i >= 1) begin
                mem_rdy += int'(memReady);
                alu_rdy += int'(aluReady);
            end
            tick();
        end
        aluValid = 1'b0; memValid = 1'b0;
        tick();
        tick();
        tick();
`ifdef RF_ARB_ROUND_ROBIN_EN
        chk("t3_mem_duty", 64'(mem_rdy), 64'd4);
        chk("t3_alu_duty", 64'(alu_rdy), 64'd4);
`else
        chk("t3_mem_duty", 64'(mem_rdy), 64'd8);
        chk("t3_alu_duty", 64'(alu_rdy), 64'd0);
`endif
        chk("t3_sb_empty", 64'(sb_q.size()), 64'd0);

        // Zero register: accepted, dropped, never pending.
        aluValid = 1'b1; aluAddress = 5'd31; aluData = 32'hFFFFFFFF;
        chk("t4_alu_rdy", 64'(aluReady), 64'd1);
        tick();
        aluValid = 1'b0;
        chk("t4_wr0", 64'(writeRegister), 64'd0);
        chk("t4_mask", 64'(pendingMask), 64'd0);
        chk("t4_alu_rdy_after", 64'(aluReady), 64'd1);
        tick();
        chk("t4_wr1", 64'(writeRegister), 64'd0);
        chk("t4_mask31", 64'(pendingMask[31]), 64'd0);

        // Asynchronous reset with slots occupied and a write on the port.
        aluValid = 1'b1; aluAddress = 5'd8; aluData = 32'h88;
        memValid = 1'b1; memAddress = 5'd9; memData = 32'h99;
        sb_q.push_back(mk(9, 32'h99));
        tick();
        aluValid = 1'b0; memValid = 1'b0;
        tick();
        chk("t5_wr_before", 64'(writeRegister), 64'd1);
        chk("t5_mask_before", 64'(pendingMask), 64'h300);
        reset = 1'b1;
        #1;
        chk("t5_rst_wr", 64'(writeRegister), 64'd0);
        chk("t5_rst_addr", 64'(writeAddress), 64'd0);
        chk("t5_rst_data", 64'(writeData), 64'd0);
        chk("t5_rst_mask", 64'(pendingMask), 64'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_write", 64'(writeRegister), 64'd0);
        end

        // Mem streaming 1 write per cycle with no bubbles.
        for (int i = 1; i <= 10; i++) begin
            memValid = 1'b1; memAddress = ADDR_WIDTH'(i); memData = 32'h100 + i;
            chk("t6_mem_rdy", 64'(memReady), 64'd1);
            sb_q.push_back(mk(i, 32'h100 + i));
            tick();
            if (i >= 2) chk("t6_no_bubble", 64'(writeRegister), 64'd1);
        end
        memValid = 1'b0;
        tick();
        chk("t6_last", 64'(writeRegister), 64'd1);
        tick();
        chk("t6_idle", 64'(writeRegister), 64'd0);
        chk("t6_rf10", 64'(rf_model[10]), 64'h10A);
        chk("t6_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU result path and the memory/load path.
- Each requester has a valid/ready handshake and a one-entry holding slot.
- The arbiter grants one slot per cycle and drives registered writeRegister/writeAddress/writeData into the register file.
- Also exports a pending-write mask so hazard logic can stall reads of registers with writes still in flight.

Parameters:
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, width of register address
- ZERO_REG, 31, register hardwired to zero; writes to it are discarded

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- aluValid  input  1  ALU write request present
- aluReady  output  1  ALU slot can accept this cycle
- aluAddress  input  ADDR_WIDTH  ALU destination register
- aluData  input  DATA_WIDTH  ALU result
- memValid  input  1  memory write request present
- memReady  output  1  memory slot can accept this cycle
- memAddress  input  ADDR_WIDTH  memory destination register
- memData  input  DATA_WIDTH  load data
- writeRegister  output  1  write-enable to register file, registered
- writeAddress  output  ADDR_WIDTH  write address to register file, registered
- writeData  output  DATA_WIDTH  write data to register file, registered
- pendingMask  output  2**ADDR_WIDTH  bit r set while a write to r is buffered or on the port

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - both slots empty; writeRegister=0, writeAddress=0, writeData=0
  - round-robin pointer = mem; pendingMask=0
  - buffered requests are lost.
- Handshake:
  - a request is accepted on a rising edge when xValid && xReady.
  - xReady = slot empty OR slot granted this cycle, so one requester sustains 1 write/cycle.
  - xReady is independent of xValid.
- Zero register:
  - a request with address == ZERO_REG is accepted normally (ready rules unchanged).
  - it is discarded at acceptance, never occupies the slot and never reaches the port.
- Arbitration: combinational each cycle among occupied slots; exactly one grant when at least one slot is occupied.
  - Default: fixed priority, mem over ALU.
  - ALU may starve while the mem slot is refilled every cycle; this is intended.
- Issue:
  - on the edge where a slot is granted, its addr/data load into the output registers, writeRegister=1 and the slot frees.
  - With no grant, writeRegister=0 on that edge; writeAddress/writeData hold their last values.
- Latency:
  - request accepted at edge k -> writeRegister high after edge k+1 -> register file commits at edge k+2.
  - A losing slot adds one cycle per lost arbitration.
- Same-address conflict: both slots targeting register r are issued in grant order; the later grant wins in the register file.
- pendingMask:
  - OR of one-hot(slot address) for each occupied slot, plus one-hot(writeAddress) when writeRegister=1.
  - combinational from registers only; never has bit ZERO_REG set.
- No internal FSM beyond slot-occupied flags and the round-robin pointer.

Optional Feature:
- Macro RF_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - The pointer flips to the other requester after each grant and selects only when both slots are occupied.
  - Both continuously busy -> strictly alternating grants, starting with mem after reset.
- Undefined: fixed priority, mem over ALU; no pointer register is synthesized.

Decomposition:
- Shared package rf_pkg contains:
  - constants DATA_WIDTH, ADDR_WIDTH, ZERO_REG
  - typedef rf_wr_req_t {addr, data}
  - requester-index enum {REQ_MEM, REQ_ALU}
- One sub-module, rf_wb_slot: a one-entry holding register with valid/ready, zero-register drop and a free-on-grant input. It is instantiated twice.

Test Plan:
- Reset, then a single ALU request addr=3 data=0xDEADBEEF -> writeRegister=1 for exactly one cycle, 2 edges after acceptance; writeAddress=3, writeData=0xDEADBEEF; pendingMask bit 3 clears after that cycle.
- ALU and mem valid in the same cycle, addr=7, data 0x11 (ALU) / 0x22 (mem), fixed priority -> port issues mem 0x22 then ALU 0x11 on consecutive cycles; register 7 ends at 0x11.
- Both requesters valid for 8 cycles with RF_ARB_ROUND_ROBIN_EN -> grants alternate mem, alu, mem, ...; each ready duty cycle is 50%.
- Write to addr=31, data=0xFFFFFFFF -> accepted (aluReady=1); writeRegister stays 0; pendingMask bit 31 never set.
- Assert reset asynchronously while both slots are occupied -> all outputs 0 immediately (before the next clock edge); no write is issued after reset deasserts.
- Mem valid every cycle for 10 cycles (addr 1..10) -> ten back-to-back write pulses, memReady constantly 1, no bubbles.
